pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 5-stage pipelined processor. It detects RAW data hazards between ID and EXE/MEM, handles taken-branch flushes, and sequences multi-cycle SRAM accesses with a wait-state FSM. From these it generates the freeze/flush controls that drive the PC register, the IF/ID stage register, the ID/EXE stage register and the EXE/MEM/WB stage registers.

## Interface
Parameters:
- MEM_WAIT_CYCLES, 6: cycles an instruction occupies the MEM stage for a data-memory access; legal range 2..15.
- REG_ADDR_W, 4: register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_src1  in  REG_ADDR_W  ID-stage source register 1
- id_src2  in  REG_ADDR_W  ID-stage source register 2
- id_has_src1  in  1  instruction reads src1
- id_two_src  in  1  instruction reads src2
- exe_dest  in  REG_ADDR_W  EXE-stage destination register
- exe_wb_en  in  1  EXE-stage instruction writes back
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_dest  in  REG_ADDR_W  MEM-stage destination register
- mem_wb_en  in  1  MEM-stage instruction writes back
- mem_req  in  1  MEM-stage instruction accesses data memory (load or store)
- branch_taken  in  1  EXE-stage branch resolved taken
- pc_freeze  out  1  hold PC
- if_freeze  out  1  hold IF/ID register
- if_flush  out  1  clear IF/ID register
- id_flush  out  1  clear ID/EXE register (bubble)
- stall_all  out  1  hold PC and all stage registers
- mem_start  out  1  one-cycle strobe to SRAM interface
- mem_ready  out  1  access completes this cycle

## Operation
- FSM states: RUN, WAIT. Down-counter cnt is 4 bits wide.
- RUN with mem_req=1:
  - stall_all=1 and mem_start=1.
  - Next state WAIT; cnt loads MEM_WAIT_CYCLES-2.
- WAIT with cnt!=0: stall_all=1; cnt decrements.
- WAIT with cnt==0:
  - stall_all=0 and mem_ready=1; the pipeline advances.
  - Next state RUN.
- mem_start never repeats for the same instruction.
- mem_req is sampled only in RUN.
- Hazard (default): (id_has_src1 & match(id_src1)) | (id_two_src & match(id_src2)), where match(r) = (exe_wb_en & r==exe_dest) | (mem_wb_en & r==mem_dest).
- Priority, highest first:
  1. stall_all: all other outputs forced 0. branch_taken and hazards are re-evaluated after the stall, because the stage registers hold them.
  2. branch_taken: if_flush=1 and id_flush=1; hazard ignored.
  3. hazard: pc_freeze=1, if_freeze=1, id_flush=1.
- Outputs are combinational from state, cnt and inputs.

## Timing
- Reset: state=RUN, cnt=0. While rst=1, every output is 0 regardless of inputs.
- Reset asserted mid-WAIT aborts the access. After release, mem_start re-asserts only if mem_req=1 in RUN.
- Memory access stalls the pipeline for exactly MEM_WAIT_CYCLES-1 cycles. mem_ready comes MEM_WAIT_CYCLES-1 cycles after mem_start.
- With MEM_WAIT_CYCLES=2, WAIT lasts one cycle, with cnt=0 on entry.
- A back-to-back memory instruction arriving in MEM the cycle after mem_ready starts a new access immediately.
- Hazard stall lasts until the producer leaves MEM:
  - default build: up to 2 cycles;
  - FORWARDING_EN build: exactly 1 cycle.
- Branch flush is single-cycle; it is never stretched.

## Configuration
- FORWARDING_EN defined:
  - hazard = exe_mem_r_en & exe_wb_en & ((id_has_src1 & id_src1==exe_dest) | (id_two_src & id_src2==exe_dest));
  - the MEM-stage comparison is removed, and forwarding covers all other cases.
- FORWARDING_EN undefined: the default full hazard equation applies.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state encoding (RUN=1'b0, WAIT=1'b1);
  - REG_ADDR_W default;
  - MEM_WAIT_CYCLES default.
- Sub-module hazard_detect: purely combinational hazard equation, including the FORWARDING_EN variant.
- The FSM and counter stay in pipeline_ctrl.

## Test plan
- Reset: assert rst with mem_req=1 and branch_taken=1 -> all outputs 0. Deassert rst -> mem_start=1 on the first cycle.
- Load at MEM_WAIT_CYCLES=6: mem_req=1 -> stall_all=1 for 5 cycles, mem_ready=1 on the 6th, mem_start asserted only once.
- RAW, default build: exe_dest=3, exe_wb_en=1, id_src1=3, id_has_src1=1 -> pc_freeze=if_freeze=id_flush=1. With mem_dest=3 instead, same response. With id_src2=3 and id_two_src=0 -> no stall.
- FORWARDING_EN build: same EXE match, exe_mem_r_en=0 -> no stall. With exe_mem_r_en=1 -> 1-cycle stall. MEM-stage match alone -> no stall.
- Simultaneous events:
  - branch_taken=1 with hazard active -> if_flush=id_flush=1, pc_freeze=0;
  - branch_taken=1 during WAIT -> no flush until the stall releases.
- Reset mid-WAIT (cnt=2) -> RUN with cnt=0, stall_all=0 at once. Next mem_req -> full 5-cycle stall.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encoding
// and default widths/latencies.
package cpu_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int CNT_W               = 4;
  localparam int REG_ADDR_W_DEF      = 4;
  localparam int MEM_WAIT_CYCLES_DEF = 6;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detector between ID and EXE/MEM. With FORWARDING_EN defined only
// a load in EXE feeding ID stalls; otherwise any EXE/MEM producer stalls.
module hazard_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_has_src1,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

`ifdef FORWARDING_EN
  logic unused_mem_stage;
  assign unused_mem_stage = ^{mem_dest, mem_wb_en};

  assign hazard = exe_mem_r_en & exe_wb_en &
                  ((id_has_src1 & (id_src1 == exe_dest)) |
                   (id_two_src  & (id_src2 == exe_dest)));
`else
  logic unused_load_flag;
  logic match1;
  logic match2;
  assign unused_load_flag = exe_mem_r_en;

  assign match1 = (exe_wb_en & (id_src1 == exe_dest)) | (mem_wb_en & (id_src1 == mem_dest));
  assign match2 = (exe_wb_en & (id_src2 == exe_dest)) | (mem_wb_en & (id_src2 == mem_dest));
  assign hazard = (id_has_src1 & match1) | (id_two_src & match2);
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: SRAM wait-state FSM plus branch/hazard
// priority logic. Build option FORWARDING_EN narrows the hazard equation.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
  parameter int REG_ADDR_W      = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_has_src1,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  branch_taken,
  output logic                  pc_freeze,
  output logic                  if_freeze,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic                  stall_all,
  output logic                  mem_start,
  output logic                  mem_ready
);

  // The RUN cycle that issues mem_start is itself a stall cycle, hence -2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_has_src1  (id_has_src1),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_freeze = 1'b0;
    if_freeze = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    stall_all = 1'b0;
    mem_start = 1'b0;
    mem_ready = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req) begin
          stall_all = 1'b1;
          mem_start = 1'b1;
          state_d   = WAIT;
          cnt_d     = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall_all = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          mem_ready = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Stage registers hold branch/hazard during a stall, so they resolve after it.
    if (!stall_all) begin
      if (branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (hazard) begin
        pc_freeze = 1'b1;
        if_freeze = 1'b1;
        id_flush  = 1'b1;
      end
    end

    if (rst) begin
      pc_freeze = 1'b0;
      if_freeze = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      stall_all = 1'b0;
      mem_start = 1'b0;
      mem_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_WAIT_CYCLES=6).
// Output vector order: {pc_freeze, if_freeze, if_flush, id_flush, stall_all, mem_start, mem_ready}.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_has_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_req, branch_taken;
  logic       pc_freeze, if_freeze, if_flush, id_flush, stall_all, mem_start, mem_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int starts;

  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_START  = 7'b0000110;
  localparam logic [6:0] O_STALL  = 7'b0000100;
  localparam logic [6:0] O_READY  = 7'b0000001;
  localparam logic [6:0] O_HAZ    = 7'b1101000;
  localparam logic [6:0] O_BRANCH = 7'b0011000;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_WAIT_CYCLES(6), .REG_ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_has_src1  (id_has_src1),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_req      (mem_req),
    .branch_taken (branch_taken),
    .pc_freeze    (pc_freeze),
    .if_freeze    (if_freeze),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .stall_all    (stall_all),
    .mem_start    (mem_start),
    .mem_ready    (mem_ready)
  );

  wire [6:0] outs = {pc_freeze, if_freeze, if_flush, id_flush, stall_all, mem_start, mem_ready};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hazard_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_has_src1 = 1'b0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
  endtask

  // Full access from RUN: 1 start cycle, 4 stall cycles, then ready.
  task automatic access(input logic br, input string tag);
    logic [6:0] exp;
    starts = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      mem_req = 1'b1;
      branch_taken = br;
      #1;
      if (i == 1)      exp = O_START;
      else if (i < 6)  exp = O_STALL;
      else             exp = br ? 7'b0011001 : O_READY;
      chk($sformatf("%s_c%0d", tag, i), 32'(outs), 32'(exp));
      starts += int'(mem_start);
    end
    chk({tag, "_single_start"}, 32'(starts), 32'd1);
  endtask

  initial begin
    // Reset with active requests: everything quiet.
    rst = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    clear_hazard_inputs();
    id_src1 = 4'd3; id_has_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1; chk("rst_outputs0", 32'(outs), 32'(O_NONE));
    @(negedge clk); #1; chk("rst_outputs1", 32'(outs), 32'(O_NONE));

    // Release reset with mem_req held: start on the first cycle, then full access.
    @(negedge clk);
    clear_hazard_inputs();
    branch_taken = 1'b0;
    rst = 1'b0;
    #1; chk("rel_start", 32'(outs), 32'(O_START));
    starts = int'(mem_start);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk); #1;
      chk($sformatf("first_access_c%0d", i), 32'(outs), 32'(i < 6 ? O_STALL : O_READY));
      starts += int'(mem_start);
    end
    chk("first_single_start", 32'(starts), 32'd1);
    @(negedge clk); mem_req = 1'b0; #1;
    chk("idle_after_access", 32'(outs), 32'(O_NONE));

    // RAW: EXE producer (not a load)
    @(negedge clk);
    id_src1 = 4'd3; id_has_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; #1;
`ifdef FORWARDING_EN
    chk("raw_exe_alu", 32'(outs), 32'(O_NONE));
`else
    chk("raw_exe_alu", 32'(outs), 32'(O_HAZ));
`endif
    // EXE producer is a load
    exe_mem_r_en = 1'b1; #1;
    chk("raw_exe_load", 32'(outs), 32'(O_HAZ));

    // MEM producer only
    @(negedge clk);
    clear_hazard_inputs();
    id_src1 = 4'd3; id_has_src1 = 1'b1; mem_dest = 4'd3; mem_wb_en = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; #1;
`ifdef FORWARDING_EN
    chk("raw_mem", 32'(outs), 32'(O_NONE));
`else
    chk("raw_mem", 32'(outs), 32'(O_HAZ));
`endif

    // src2 matches but is not read
    @(negedge clk);
    clear_hazard_inputs();
    id_src1 = 4'd5; id_has_src1 = 1'b1; id_src2 = 4'd3; id_two_src = 1'b0;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; #1;
    chk("src2_unused", 32'(outs), 32'(O_NONE));
    id_two_src = 1'b1; #1;
    chk("src2_used_load", 32'(outs), 32'(O_HAZ));
    // Matching destination but no writeback
    exe_wb_en = 1'b0; #1;
    chk("no_wb_en", 32'(outs), 32'(O_NONE));

    // Branch beats hazard; next cycle without branch is clean (not stretched)
    @(negedge clk);
    clear_hazard_inputs();
    id_src1 = 4'd3; id_has_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    branch_taken = 1'b1; #1;
    chk("branch_over_hazard", 32'(outs), 32'(O_BRANCH));
    @(negedge clk);
    clear_hazard_inputs();
    branch_taken = 1'b0; #1;
    chk("branch_single_cycle", 32'(outs), 32'(O_NONE));

    // Branch held across an access: flush only once the stall releases
    access(1'b1, "branch_in_wait");

    // Back-to-back access right after mem_ready
    @(negedge clk);
    branch_taken = 1'b0; mem_req = 1'b1; #1;
    chk("b2b_start", 32'(outs), 32'(O_START));
    @(negedge clk); #1; chk("b2b_cnt4", 32'(outs), 32'(O_STALL));
    @(negedge clk); #1; chk("b2b_cnt3", 32'(outs), 32'(O_STALL));
    @(negedge clk); #1; chk("b2b_cnt2", 32'(outs), 32'(O_STALL));

    // Reset mid-WAIT aborts the access immediately
    rst = 1'b1; mem_req = 1'b0; #1;
    chk("rst_mid_wait", 32'(outs), 32'(O_NONE));
    @(negedge clk); rst = 1'b0; #1;
    chk("after_abort_idle0", 32'(outs), 32'(O_NONE));
    @(negedge clk); #1;
    chk("after_abort_idle1", 32'(outs), 32'(O_NONE));

    // Next request gets the full stall
    access(1'b0, "post_abort_access");
    @(negedge clk); mem_req = 1'b0; #1;
    chk("final_idle", 32'(outs), 32'(O_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
